convmax_sequencer: RTL and testbench
====================================

// Module: convmax_sequencer
// PURPOSE
// Avalon-MM slave front end that sequences one convmax engine per scan line.
// - Accepts 120-pixel line + 8-tap half-gaussian writes into a one-deep pending buffer.
// - Holds engine inputs stable, starts the engine, waits for ready, latches the result.
// - Exposes result/status to the host; sits between the bus fabric and the convmax datapath.
// PARAMETERS
// TIMEOUT_CYC  4096  max cycles from cm_start to cm_ready before the error flag sets
// CNT_W        16    width of line sequence counter
// PORTS
// clk           in   1     system clock
// reset_n       in   1     asynchronous active-low reset
// write         in   1     Avalon write strobe
// read          in   1     Avalon read strobe
// address       in   8     word address (0x00 line, 0x01 result, 0x02 status, 0x03 count)
// byteenable    in   128   byte enables; full-line write requires all ones, else ignored
// writedata     in   1024  [959:0] pixels, [1023:960] gaussian half-kernel
// readdata      out  1024  read word; unused bits zero
// waitrequest   out  1     bus stall
// cm_indata     out  960   engine pixel input (stable while busy)
// cm_gauss      out  64    engine kernel input (stable while busy)
// cm_start      out  1     one-cycle engine launch pulse
// cm_ready      in   1     engine result-valid pulse
// cm_maxval     in   16    engine peak value
// cm_maxpos     in   8     engine peak index
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, pending/result-valid/error clear, counter 0.
// - FSM: IDLE -> LAUNCH (pending full) -> BUSY (cm_start issued) -> IDLE (cm_ready or timeout).
//   - LAUNCH: pending moves to engine regs, pending empties, cm_start=1 for exactly one cycle.
//   - BUSY: timer counts from 1; cm_ready latches {maxpos,maxval}, sets rvalid, seq++ mod 2^CNT_W.
//   - Timer == TIMEOUT_CYC without ready: err=1, rvalid unchanged, back to IDLE.
// - Write 0x00, full byteenable: pending empty -> accept same cycle, waitrequest=0.
//   - Pending full: waitrequest=1 until the next LAUNCH drains it; data captured that cycle.
//   - Partial byteenable: no capture, waitrequest=0, err=1.
// - Read 0x01: readdata[15:0]=maxval, [23:16]=maxpos, [24]=rvalid, [31:25]=0.
//   - Zero wait states; clears rvalid on the same cycle.
// - Read 0x02: [0]=busy, [1]=pending full, [2]=rvalid, [3]=err.
//   - Write 0x02 with writedata[3]=1 clears err.
// - Simultaneous events:
//   - cm_ready and read 0x01 same cycle: read returns old result; new result stored, rvalid=1.
//   - LAUNCH and stalled write same cycle: the write lands in the freed pending slot.
// - cm_ready outside BUSY is ignored. Unmapped addresses: read 0, write no effect, no stall.
// - Reads never stall. readdata is registered: valid the cycle after read with waitrequest=0.
// - reset_n low mid-operation: FSM aborts, pending and result discarded, cm_start forced 0.
// CONFIGURATION
// CONVMAX_LINE_CNT_EN defined: address 0x03 reads {zeros, seq[CNT_W-1:0]}.
//   - Any write to 0x03 zeroes seq; a same-cycle cm_ready loses to the write.
// Undefined: seq logic removed; 0x03 reads 0; 0x01 and 0x02 behaviour identical.
// TESTING
// - Reset, write line (pixel 37=0xFF), engine returns 0x1234/37 -> read 0x01 = 0x0125_1234.
// - Two back-to-back writes while busy: second accepted; third stalls until LAUNCH; three starts total.
// - Engine never asserts ready with TIMEOUT_CYC=16 -> status 0x08 after 17 cycles; clear -> 0x00.
// - Partial byteenable 0x0F..0 write to 0x00 -> no cm_start, err=1.
// - cm_ready coincident with read 0x01 -> old value returned; next read shows new value, bit24=1.
// - With CONVMAX_LINE_CNT_EN: 5 lines -> 0x03 reads 5; write 0x03 -> reads 0.
// - Without it: 0x03 reads 0.

Source files
------------

// File: rtl/convmax_sequencer.sv
// Avalon-MM front end that feeds one convmax engine per scan line: one-deep pending
// line buffer, engine launch/wait sequencing, result/status registers. Optional line
// counter at 0x03 is enabled by defining CONVMAX_LINE_CNT_EN.
module convmax_sequencer #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          write,
  input  logic          read,
  input  logic [7:0]    address,
  input  logic [127:0]  byteenable,
  input  logic [1023:0] writedata,
  output logic [1023:0] readdata,
  output logic          waitrequest,
  output logic [959:0]  cm_indata,
  output logic [63:0]   cm_gauss,
  output logic          cm_start,
  input  logic          cm_ready,
  input  logic [15:0]   cm_maxval,
  input  logic [7:0]    cm_maxpos
);

  // state  | meaning
  // IDLE   | engine free; launches as soon as the pending slot is full
  // LAUNCH | engine inputs loaded, cm_start high for this single cycle
  // BUSY   | waiting for cm_ready; down-counter expires after TIMEOUT_CYC cycles
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY} state_t;

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [1023:0]     pend;
  logic              pend_full;
  logic              rvalid;
  logic              err;
  logic [15:0]       res_val;
  logic [7:0]        res_pos;
  logic [CNT_W-1:0]  seq;

  logic be_full, line_wr, drain, line_accept, line_bad;
  logic err_clr, rd_res, ready_hit, timeout;
  logic [31:0] rd_word;

  assign be_full     = &byteenable;
  assign line_wr     = write && (address == 8'h00);
  assign drain       = (state == S_IDLE) && pend_full;
  // A stalled line write is released in the very cycle the slot drains.
  assign waitrequest = line_wr && be_full && pend_full && !drain;
  assign line_accept = line_wr && be_full && (!pend_full || drain);
  assign line_bad    = line_wr && !be_full;
  assign err_clr     = write && (address == 8'h02) && writedata[3];
  assign rd_res      = read && (address == 8'h01);
  assign ready_hit   = (state == S_BUSY) && cm_ready;
  assign timeout     = (state == S_BUSY) && !cm_ready && (tmr == '0);

  always_comb begin
    rd_word = '0;
    case (address)
      8'h01:   rd_word = {7'b0, rvalid, res_pos, res_val};
      8'h02:   rd_word = {28'b0, err, rvalid, pend_full, state != S_IDLE};
      8'h03:   rd_word = 32'(seq);
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      res_val   <= '0;
      res_pos   <= '0;
      cm_indata <= '0;
      cm_gauss  <= '0;
      cm_start  <= 1'b0;
      readdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pend_full) begin
            cm_indata <= pend[959:0];
            cm_gauss  <= pend[1023:960];
            cm_start  <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cm_start <= 1'b0;
          tmr      <= TMR_W'(TIMEOUT_CYC - 1);
          state    <= S_BUSY;
        end
        S_BUSY: begin
          if (cm_ready) begin
            res_val <= cm_maxval;
            res_pos <= cm_maxpos;
            state   <= S_IDLE;
          end else if (tmr == '0) begin
            state <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          cm_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase

      if (line_accept) begin
        pend      <= writedata;
        pend_full <= 1'b1;
      end else if (drain) begin
        pend_full <= 1'b0;
      end

      // A result arriving during the result read wins: the read sees the old word.
      if (ready_hit)
        rvalid <= 1'b1;
      else if (rd_res)
        rvalid <= 1'b0;

      if (line_bad || timeout)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;

      readdata <= read ? 1024'(rd_word) : '0;
    end
  end

`ifdef CONVMAX_LINE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      seq <= '0;
    else if (write && (address == 8'h03))
      seq <= '0;
    else if (ready_hit)
      seq <= seq + CNT_W'(1);
  end
`else
  assign seq = '0;
`endif

endmodule

// File: tb/tb_convmax_sequencer.sv
// Directed bench for convmax_sequencer: bus reads are checked through a scoreboard
// queue, engine handshakes are driven by hand from the single stimulus block.
module tb_convmax_sequencer;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          write, read;
  logic [7:0]    address;
  logic [127:0]  byteenable;
  logic [1023:0] writedata;
  logic [1023:0] readdata;
  logic          waitrequest;
  logic [959:0]  cm_indata;
  logic [63:0]   cm_gauss;
  logic          cm_start;
  logic          cm_ready;
  logic [15:0]   cm_maxval;
  logic [7:0]    cm_maxpos;

  convmax_sequencer #(.TIMEOUT_CYC(16), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .read(read), .address(address),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .cm_indata(cm_indata), .cm_gauss(cm_gauss),
    .cm_start(cm_start), .cm_ready(cm_ready), .cm_maxval(cm_maxval), .cm_maxpos(cm_maxpos)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [1023:0] exp; } sb_t;
  sb_t sb[$];

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  always @(posedge clk) if (cm_start === 1'b1) start_cnt <= start_cnt + 1;

  localparam logic [127:0] BE_ALL = '1;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed[63:0]=%h expected[63:0]=%h differing_bits=%0d",
             tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [1023:0] d, input logic [127:0] be,
                    output int waited);
    address = a; writedata = d; byteenable = be; write = 1'b1; waited = 0;
    @(negedge clk);
    while (waitrequest === 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    write = 1'b0; address = '0; byteenable = '0; writedata = '0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag,
                    input bit rdy = 1'b0, input logic [15:0] v = '0, input logic [7:0] p = '0);
    sb_t e;
    e.tag = tag; e.exp = 1024'(exp);
    sb.push_back(e);
    address = a; read = 1'b1;
    if (rdy) begin cm_ready = 1'b1; cm_maxval = v; cm_maxpos = p; end
    @(posedge clk); #1;
    read = 1'b0; cm_ready = 1'b0; address = '0;
    e = sb.pop_front();
    chk(e.tag, readdata, e.exp);
  endtask

  // Returns one cycle after the launch, i.e. with the engine in BUSY.
  task automatic wait_start(input logic [1023:0] line, input string tag);
    int n = 0;
    @(negedge clk);
    while (cm_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, 1024'(cm_start), 1024'(1'b1));
    chk({tag, "_indata"}, 1024'(cm_indata), 1024'(line[959:0]));
    chk({tag, "_gauss"}, 1024'(cm_gauss), 1024'(line[1023:960]));
    @(posedge clk); #1;
  endtask

  task automatic engine_reply(input int dly, input logic [15:0] v, input logic [7:0] p);
    repeat (dly) @(posedge clk);
    #1;
    cm_ready = 1'b1; cm_maxval = v; cm_maxpos = p;
    @(posedge clk); #1;
    cm_ready = 1'b0;
  endtask

  function automatic logic [1023:0] mk_line();
    logic [1023:0] l;
    for (int i = 0; i < 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] l1, la, lb, lc, ld, le, lr;
    logic [127:0]  be_part;
    int w, s0;
`ifdef CONVMAX_LINE_CNT_EN
    int exp_cnt = 5;
`else
    int exp_cnt = 0;
`endif

    reset_n = 1'b0; write = 1'b0; read = 1'b0; address = '0; byteenable = '0;
    writedata = '0; cm_ready = 1'b0; cm_maxval = '0; cm_maxpos = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, '0);
    chk("rst_cm_start", 1024'(cm_start), '0);
    chk("rst_cm_indata", 1024'(cm_indata), '0);
    chk("rst_cm_gauss", 1024'(cm_gauss), '0);
    chk("rst_waitreq", 1024'(waitrequest), '0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h02, 32'h0, "rst_status");

    // Basic line: pixel 37 = 0xFF, engine reports 0x1234 at 37.
    l1 = '0; l1[37*8 +: 8] = 8'hFF; l1[1023:960] = 64'h0102_0408_1020_4080;
    wr(8'h00, l1, BE_ALL, w);
    chk("l1_nowait", 1024'(w), '0);
    wait_start(l1, "l1");
    engine_reply(2, 16'h1234, 8'd37);
    rd(8'h02, 32'h04, "l1_status");
    rd(8'h01, 32'h0125_1234, "l1_result");
    rd(8'h01, 32'h0025_1234, "l1_result_cleared");
    rd(8'h02, 32'h00, "l1_status_after");

    // Back-to-back lines: second fills pending, third stalls until the slot drains.
    s0 = start_cnt;
    la = mk_line(); lb = mk_line(); lc = mk_line();
    wr(8'h00, la, BE_ALL, w);
    wait_start(la, "la");
    wr(8'h00, lb, BE_ALL, w);
    chk("lb_nowait", 1024'(w), '0);
    rd(8'h02, 32'h03, "busy_pend_status");
    address = 8'h00; writedata = lc; byteenable = BE_ALL; write = 1'b1;
    @(negedge clk);
    chk("lc_stall0", 1024'(waitrequest), 1024'(1'b1));
    @(posedge clk); #1;
    cm_ready = 1'b1; cm_maxval = 16'h0001; cm_maxpos = 8'd1;
    @(negedge clk);
    chk("lc_stall1", 1024'(waitrequest), 1024'(1'b1));
    @(posedge clk); #1;
    cm_ready = 1'b0;
    @(negedge clk);
    chk("lc_release", 1024'(waitrequest), '0);
    @(posedge clk); #1;
    write = 1'b0; byteenable = '0; writedata = '0;
    chk("lb_start", 1024'(cm_start), 1024'(1'b1));
    chk("lb_indata", 1024'(cm_indata), 1024'(lb[959:0]));
    rd(8'h02, 32'h07, "launch_status");
    engine_reply(1, 16'h0002, 8'd2);
    wait_start(lc, "lc");
    engine_reply(1, 16'h0003, 8'd3);
    chk("three_starts", 1024'(start_cnt - s0), 1024'(3));
    rd(8'h01, 32'h0103_0003, "lc_result");

    // Engine never answers: err after 17 cycles from cm_start, not before.
    ld = mk_line();
    wr(8'h00, ld, BE_ALL, w);
    wait_start(ld, "ld");
    repeat (15) @(posedge clk);
    #1;
    rd(8'h02, 32'h01, "pre_timeout_status");
    rd(8'h02, 32'h08, "timeout_status");
    wr(8'h02, 1024'(32'h8), BE_ALL, w);
    rd(8'h02, 32'h00, "err_cleared");
    engine_reply(0, 16'hBEEF, 8'hEE);
    rd(8'h01, 32'h0003_0003, "ready_outside_busy");

    // Partial byteenable on a line write.
    s0 = start_cnt;
    be_part = '0; be_part[123:120] = 4'hF;
    wr(8'h00, mk_line(), be_part, w);
    chk("partial_nowait", 1024'(w), '0);
    repeat (5) @(posedge clk);
    #1;
    chk("partial_no_start", 1024'(start_cnt - s0), '0);
    rd(8'h02, 32'h08, "partial_err");
    wr(8'h02, 1024'(32'h8), BE_ALL, w);

    // Unmapped address.
    wr(8'h10, mk_line(), BE_ALL, w);
    chk("unmapped_nowait", 1024'(w), '0);
    rd(8'h10, 32'h0, "unmapped_read");

    // Result arriving on the same cycle as the result read.
    le = mk_line();
    wr(8'h00, le, BE_ALL, w);
    wait_start(le, "le");
    rd(8'h01, 32'h0003_0003, "coincident_old", 1'b1, 16'h5555, 8'h55);
    rd(8'h01, 32'h0155_5555, "coincident_new");
    rd(8'h01, 32'h0055_5555, "coincident_cleared");

    // Line counter.
    wr(8'h03, '0, BE_ALL, w);
    rd(8'h03, 32'h0, "cnt_zeroed");
    for (int i = 0; i < 5; i++) begin
      lr = mk_line();
      wr(8'h00, lr, BE_ALL, w);
      wait_start(lr, "cnt_line");
      engine_reply(1, 16'(i), 8'(i));
    end
    rd(8'h03, 32'(exp_cnt), "cnt_five");
    wr(8'h03, '0, BE_ALL, w);
    rd(8'h03, 32'h0, "cnt_cleared");

    // Reset while cm_start is high.
    lr = mk_line();
    wr(8'h00, lr, BE_ALL, w);
    @(posedge clk); #1;
    chk("mid_start", 1024'(cm_start), 1024'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_start", 1024'(cm_start), '0);
    chk("mid_rst_indata", 1024'(cm_indata), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h02, 32'h00, "post_rst_status");
    rd(8'h01, 32'h0, "post_rst_result");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
